// File: rtl/binary_to_bcd_seq_if.sv
// binary_to_bcd_seq_if: start/operand request and BCD result bundle for the sequential converter
interface binary_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS = 5
);
  logic start;
  logic [BIN_WIDTH-1:0] binary_in;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] bcd_out;
  logic overflow;
  modport master (output start, binary_in, input busy, done, bcd_out, overflow);
  modport slave (input start, binary_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: double-dabble binary-to-BCD converter, one shift per clock
module binary_to_bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS = 5
) (
  input logic clk,
  input logic rst_n,
  binary_to_bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_WIDTH;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int LW = (BIN_WIDTH > BW ? BIN_WIDTH : BW) + 1;
  function automatic logic [LW-1:0] pow10_m1(input int n);
    logic [LW-1:0] p;
    p = LW'(1);
    for (int i = 0; i < n; i++) p = p * LW'(10);
    return p - LW'(1);
  endfunction
  localparam logic [LW-1:0] LIM = pow10_m1(DIGITS);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] scr, scr_n, adj, shifted;
  logic ovp, ovp_n, done_n, ov_n;
  logic [BW-1:0] bcd_n;
  always_comb begin
    adj = scr;
    for (int d = 0; d < DIGITS; d++)
      adj[BIN_WIDTH+4*d +: 4] = scr[BIN_WIDTH+4*d +: 4] > 4'd4 ? scr[BIN_WIDTH+4*d +: 4] + 4'd3 : scr[BIN_WIDTH+4*d +: 4];
  end
  // the bit leaving the top digit is dropped, which yields value mod 10^DIGITS
  assign shifted = {adj[SW-2:0], 1'b0};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    scr_n = scr;
    ovp_n = ovp;
    bcd_n = bus.bcd_out;
    ov_n = bus.overflow;
    done_n = 1'b0;
    if (state == IDLE && bus.start) begin
      scr_n = {{BW{1'b0}}, bus.binary_in};
      cnt_n = CW'(BIN_WIDTH);
      ovp_n = {{(LW-BIN_WIDTH){1'b0}}, bus.binary_in} > LIM;
      state_n = SHIFT;
    end else if (state == SHIFT) begin
      scr_n = shifted;
      cnt_n = cnt - CW'(1);
      if (cnt == CW'(1)) begin
        bcd_n = shifted[SW-1 -: BW];
        ov_n = ovp;
        done_n = 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      scr <= '0;
      ovp <= 1'b0;
      bus.bcd_out <= '0;
      bus.overflow <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      scr <= scr_n;
      ovp <= ovp_n;
      bus.bcd_out <= bcd_n;
      bus.overflow <= ov_n;
      bus.done <= done_n;
    end
  assign bus.busy = state == SHIFT;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: table, random and corner-sequence checks of the BCD converter (5- and 4-digit)
module tb_binary_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  binary_to_bcd_seq_if #(.BIN_WIDTH(16), .DIGITS(5)) b16 ();
  binary_to_bcd_seq_if #(.BIN_WIDTH(16), .DIGITS(4)) b4 ();
  binary_to_bcd_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b16));
  binary_to_bcd_seq #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  typedef struct { logic [15:0] v; logic [19:0] bcd; logic ov; } vec_t;
  vec_t tbl [8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [19:0] model_bcd(input int v, input int dg);
    logic [19:0] r = '0;
    for (int i = 0; i < dg; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic dn(input bit w4);
    return w4 ? b4.done : b16.done;
  endfunction
  function automatic logic bz(input bit w4);
    return w4 ? b4.busy : b16.busy;
  endfunction
  function automatic logic [19:0] bo(input bit w4);
    return w4 ? {4'h0, b4.bcd_out} : b16.bcd_out;
  endfunction
  function automatic logic ovf(input bit w4);
    return w4 ? b4.overflow : b16.overflow;
  endfunction
  task automatic drive(input bit w4, input logic s, input logic [15:0] v);
    if (w4) begin b4.start = s; b4.binary_in = v; end
    else begin b16.start = s; b16.binary_in = v; end
  endtask
  task automatic conv(input bit w4, input logic [15:0] v, input logic [19:0] eb, input logic eo, input string nm);
    int n = 0, nb = 0;
    @(negedge clk);
    drive(w4, 1'b1, v);
    @(posedge clk);
    #1 drive(w4, 1'b0, ~v);
    if (bz(w4)) nb++;
    do begin
      @(posedge clk);
      #1 n++;
      if (bz(w4)) nb++;
      if (bz(w4) && dn(w4)) errors++;
    end while (!dn(w4) && n < 40);
    chk({nm, " latency"}, n, 16);
    chk({nm, " busy cycles"}, nb, 16);
    chk({nm, " bcd"}, bo(w4), eb);
    chk({nm, " ovf"}, ovf(w4), eo);
    @(posedge clk);
    #1 chk({nm, " done width"}, dn(w4), 0);
  endtask
  initial begin
    int n, pulses;
    logic [19:0] got;
    tbl[0] = '{16'd65535, 20'h65535, 1'b0};
    tbl[1] = '{16'd0, 20'h00000, 1'b0};
    tbl[2] = '{16'd9, 20'h00009, 1'b0};
    tbl[3] = '{16'd10, 20'h00010, 1'b0};
    tbl[4] = '{16'd1000, 20'h01000, 1'b0};
    tbl[5] = '{16'd12345, 20'h12345, 1'b0};
    tbl[6] = '{16'd59999, 20'h59999, 1'b0};
    tbl[7] = '{16'd1, 20'h00001, 1'b0};
    drive(0, 1'b0, 16'd0);
    drive(1, 1'b0, 16'd0);
    #12;
    chk("reset busy", {b16.busy, b4.busy}, 0);
    chk("reset done", {b16.done, b4.done}, 0);
    chk("reset bcd", bo(0) | bo(1), 0);
    chk("reset ovf", {b16.overflow, b4.overflow}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) conv(0, tbl[i].v, tbl[i].bcd, tbl[i].ov, $sformatf("tbl%0d", i));
    conv(1, 16'd12345, 20'h02345, 1'b1, "d4 12345");
    conv(1, 16'd9999, 20'h09999, 1'b0, "d4 9999");
    conv(1, 16'd10000, 20'h00000, 1'b1, "d4 10000");
    for (int i = 0; i < 16; i++) begin
      logic [15:0] r;
      bit w4;
      w4 = i[0];
      r = i[1] ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 12000));
      conv(w4, r, model_bcd(int'(r), w4 ? 4 : 5), int'(r) >= (w4 ? 10000 : 100000), $sformatf("rnd%0d", i));
    end
    @(negedge clk) drive(0, 1'b1, 16'd500);
    @(posedge clk);
    #1 drive(0, 1'b0, 16'd0);
    pulses = 0;
    got = '0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1 if (k == 5) drive(0, 1'b1, 16'd777);
      if (k == 6) drive(0, 1'b0, 16'd777);
      if (b16.done) begin pulses++; got = b16.bcd_out; end
    end
    chk("midstart pulses", pulses, 1);
    chk("midstart bcd", got, 20'h00500);
    @(negedge clk) drive(0, 1'b1, 16'd1000);
    @(posedge clk);
    #1 b16.binary_in = 16'd42;
    n = 0;
    do begin @(posedge clk); #1 n++; end while (!b16.done && n < 40);
    chk("held lat1", n, 16);
    chk("held bcd1", b16.bcd_out, 20'h01000);
    @(posedge clk);
    #1 chk("held no gap", {b16.busy, b16.done}, 2'b10);
    b16.start = 1'b0;
    n = 0;
    do begin @(posedge clk); #1 n++; end while (!b16.done && n < 40);
    chk("held lat2", n, 16);
    chk("held bcd2", b16.bcd_out, 20'h00042);
    conv(1, 16'd50000, 20'h00000, 1'b1, "d4 50000");
    @(negedge clk) drive(0, 1'b1, 16'd5000);
    @(posedge clk);
    #1 drive(0, 1'b0, 16'd0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", b16.busy, 0);
    chk("abort done", b16.done, 0);
    chk("abort bcd", b16.bcd_out, 0);
    chk("abort ovf4", b4.overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1 if (b16.done || b16.busy) pulses++;
    end
    chk("abort no done", pulses, 0);
    conv(0, 16'd321, 20'h00321, 1'b0, "after abort");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
